// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: 2-FF sync, shared sample-tick prescaler, per-channel
// hysteresis filter and press FSM. Define BTN_AUTO_REPEAT_EN to auto-repeat o_rise while in LONG.
module btn_debounce_multi #(
  parameter int unsigned N_CH         = 5,
  parameter int unsigned F_COUNT      = 1000,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LONG_TICKS   = 50000,
  parameter int unsigned REPEAT_TICKS = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic            o_tick
);

  localparam int unsigned CNT_W  = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_W  = $clog2(REPEAT_TICKS + 1);
`endif

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_LONG     = 2'd2;

  // Elaboration-time parameter sanity checks
  if (F_COUNT < 2) begin : g_bad_f_count
    $error("btn_debounce_multi: F_COUNT must be >= 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("btn_debounce_multi: DEPTH must be >= 2");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("btn_debounce_multi: LONG_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("btn_debounce_multi: REPEAT_TICKS must be >= 1");
  end

  logic [CNT_W-1:0] pre_cnt;
  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic             tick;

  assign tick   = (pre_cnt == CNT_W'(F_COUNT - 1));
  assign o_tick = tick;

  // Shared prescaler and input synchronizers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
      sync1   <= '0;
      sync2   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
      sync1   <= i_btn;
      sync2   <= sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DEPTH-1:0]  shreg;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;
    logic              long_q;
    logic              next_level;
    logic              lvl_up;
    logic              lvl_dn;
    logic              rise_d;
    logic              long_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RPT_W-1:0]  rpt_q;
    logic [RPT_W-1:0]  rpt_d;
    logic              rpt_fire;
`endif

    // Hysteresis: change only on a full run of equal samples
    always_comb begin
      next_level = level_q;
      if (&shreg) begin
        next_level = 1'b1;
      end else if (~|shreg) begin
        next_level = 1'b0;
      end
    end

    assign lvl_up = next_level & ~level_q;
    assign lvl_dn = ~next_level & level_q;

    // Press FSM next state; level edges take priority over tick counting
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      long_d  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_d    = '0;
      rpt_fire = 1'b0;
`endif
      case (state_q)
        ST_RELEASED: begin
          hold_d = '0;
          if (lvl_up) begin
            state_d = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (lvl_dn) begin
            state_d = ST_RELEASED;
            hold_d  = '0;
          end else if (hold_q == HOLD_W'(LONG_TICKS)) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
          end else if (tick) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (lvl_dn) begin
            state_d = ST_RELEASED;
            hold_d  = '0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (rpt_q == RPT_W'(REPEAT_TICKS)) begin
            rpt_fire = 1'b1;
          end else if (tick) begin
            rpt_d = rpt_q + RPT_W'(1);
          end else begin
            rpt_d = rpt_q;
          end
`endif
        end
        default: begin
          state_d = ST_RELEASED;
          hold_d  = '0;
        end
      endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    assign rise_d = lvl_up | rpt_fire;
`else
    assign rise_d = lvl_up;
`endif

    always_ff @(posedge clk) begin
      if (!rst) begin
        shreg   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
        state_q <= ST_RELEASED;
        hold_q  <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q   <= '0;
`endif
      end else begin
        if (tick) begin
          shreg <= {shreg[DEPTH-2:0], sync2[g]};
        end
        level_q <= next_level;
        rise_q  <= rise_d;
        fall_q  <= lvl_dn;
        long_q  <= long_d;
        state_q <= state_d;
        hold_q  <= hold_d;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q   <= rpt_d;
`endif
      end
    end

    assign o_level[g] = level_q;
    assign o_rise[g]  = rise_q;
    assign o_fall[g]  = fall_q;
    assign o_long[g]  = long_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: expected pulse events (kind, channel, cycle)
// are queued when buttons are driven and matched against every pulse the DUT emits.
module tb_btn_debounce_multi;

  localparam int unsigned N_CH         = 2;
  localparam int unsigned F_COUNT      = 4;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned LONG_TICKS   = 8;
  localparam int unsigned REPEAT_TICKS = 3;
  localparam int T_LONG = int'(LONG_TICKS * F_COUNT);
  localparam int T_RPT  = int'(REPEAT_TICKS * F_COUNT);

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] i_btn = '1;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_long;
  logic            o_tick;

  btn_debounce_multi #(
    .N_CH(N_CH), .F_COUNT(F_COUNT), .DEPTH(DEPTH),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_long(o_long), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  int edge_n   = 0;
  int rel_edge = 0;
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) edge_n++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [63:0] ev(input int kind, input int ch, input int k);
    return {8'(kind), 8'(ch), 16'd0, 32'(k)};
  endfunction

  function automatic int now_k();
    return edge_n - rel_edge;
  endfunction

  // Edge at which o_level/pulses show a change driven just after edge a:
  // two sync stages, first tick after the synced value, DEPTH-1 more ticks, one register.
  function automatic int lvl_edge(input int a);
    int t1;
    t1 = ((a + 3 + int'(F_COUNT) - 1) / int'(F_COUNT)) * int'(F_COUNT);
    return t1 + (int'(DEPTH) - 1) * int'(F_COUNT) + 1;
  endfunction

  function automatic logic pulse_of(input int kind, input int ch);
    if (kind == K_RISE) return o_rise[ch];
    if (kind == K_FALL) return o_fall[ch];
    return o_long[ch];
  endfunction

  // Every DUT pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int t = 0; t < 3; t++) begin
          if (pulse_of(t, c)) begin
            if (exp_q.size() == 0) check("unexpected_pulse", ev(t, c, now_k()), '1);
            else check("pulse_event", ev(t, c, now_k()), exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_k(input int target);
    while (now_k() < target) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int r;
    int f;

    // Reset with both buttons held: everything stays low
    rst   = 1'b0;
    i_btn = '1;
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", 64'({o_level, o_rise, o_fall, o_long, o_tick}), 64'd0);
    end

    rst      = 1'b1;
    i_btn    = '0;
    rel_edge = edge_n;
    for (int k = 0; k < 4; k++) begin
      check("tick_after_reset", 64'(o_tick), 64'(k == 3));
      if (k < 3) @(negedge clk);
    end
    mon_en = 1'b1;

    // Clean press and release on channel 0
    repeat (3) @(negedge clk);
    a = now_k();
    i_btn[0] = 1'b1;
    r = lvl_edge(a);
    check("press_latency_bound", 64'(r - a <= 23), 64'd1);
    exp_q.push_back(ev(K_RISE, 0, r));
    wait_drain("clean_rise", 40);
    check("clean_level_hi", 64'(o_level), 64'(2'b01));
    wait_k(r + 8);
    a = now_k();
    i_btn[0] = 1'b0;
    exp_q.push_back(ev(K_FALL, 0, lvl_edge(a)));
    wait_drain("clean_fall", 40);
    check("clean_level_lo", 64'(o_level), 64'd0);

    // Bounce: toggle every 3 clk for 60 clk, never a stable run
    for (int i = 0; i < 20; i++) begin
      i_btn[0] = ~i_btn[0];
      repeat (3) @(negedge clk);
    end
    i_btn[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("bounce_level", 64'(o_level), 64'd0);

    // Long press on channel 1
    a = now_k();
    i_btn[1] = 1'b1;
    r = lvl_edge(a);
    f = lvl_edge(a + 206);
    exp_q.push_back(ev(K_RISE, 1, r));
    exp_q.push_back(ev(K_LONG, 1, r + T_LONG));
`ifdef BTN_AUTO_REPEAT_EN
    for (int e = r + T_LONG + T_RPT; e < f; e += T_RPT) exp_q.push_back(ev(K_RISE, 1, e));
`endif
    wait_k(a + 206);
    i_btn[1] = 1'b0;
    exp_q.push_back(ev(K_FALL, 1, f));
    wait_drain("long_press", 80);
    check("long_level_lo", 64'(o_level), 64'd0);

    // Short press of 6 ticks: no long pulse
    a = now_k();
    i_btn[1] = 1'b1;
    r = lvl_edge(a);
    exp_q.push_back(ev(K_RISE, 1, r));
    wait_k(a + 24);
    i_btn[1] = 1'b0;
    exp_q.push_back(ev(K_FALL, 1, r + 24));
    wait_drain("short_press", 80);

    // Both channels together pulse on the same clk
    a = now_k();
    i_btn = 2'b11;
    r = lvl_edge(a);
    exp_q.push_back(ev(K_RISE, 0, r));
    exp_q.push_back(ev(K_RISE, 1, r));
    wait_k(r);
    @(negedge clk);
    check("both_level_hi", 64'(o_level), 64'(2'b11));
    wait_k(a + 20);
    i_btn = 2'b00;
    exp_q.push_back(ev(K_FALL, 0, r + 20));
    exp_q.push_back(ev(K_FALL, 1, r + 20));
    wait_drain("both_channels", 80);

    // Reset during LONG: silent clear, then a normal re-press
    a = now_k();
    i_btn[1] = 1'b1;
    r = lvl_edge(a);
    exp_q.push_back(ev(K_RISE, 1, r));
    exp_q.push_back(ev(K_LONG, 1, r + T_LONG));
    wait_k(r + T_LONG + 2);
    check("pre_reset_events", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midpress_reset_out", 64'({o_level, o_rise, o_fall, o_long, o_tick}), 64'd0);
    rst      = 1'b1;
    rel_edge = edge_n;
    r = lvl_edge(0);
    exp_q.push_back(ev(K_RISE, 1, r));
    wait_drain("repress_rise", 40);
    check("repress_level", 64'(o_level), 64'(2'b10));
    wait_k(r + 8);
    i_btn[1] = 1'b0;
    exp_q.push_back(ev(K_FALL, 1, r + 8 + 16));
    wait_drain("repress_fall", 40);

    repeat (50) @(negedge clk);
    check("idle_end_level", 64'(o_level), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
